mv_select: RTL
==============

MV_SELECT -- requirements
Module: mv_select

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 16, giving the number of candidate rows per search block (valid range 2..16).
REQ-002 SHALL have parameter SAD_W, default 12, giving the SAD field width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a new block search.
REQ-006 SHALL have port in_valid, input, 1 bit: marks in_cand as a valid row minimum.
REQ-007 SHALL have port in_cand, input, 20 bits: packed {SAD[19:8], x[7:4], y[3:0]} from the row-compare stage.
REQ-008 SHALL have port mv_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port mv_valid, output, 1 bit: result available.
REQ-010 SHALL have port mv_sad, output, SAD_W bits: best SAD of the block.
REQ-011 SHALL have port mv_x, output, 4 bits: best x; and port mv_y, output, 4 bits: best y.
REQ-012 SHALL have port busy, output, 1 bit: high in ACCUM.
REQ-013 SHALL have port drop_err, output, 1 bit: sticky flag for a discarded in_valid.

Function
REQ-014 SHALL implement three states: IDLE, ACCUM and DONE.
REQ-015 In IDLE or DONE, start SHALL load best={SAD all-ones, x=0, y=0}, clear the row counter, clear drop_err and enter ACCUM on the next cycle; in DONE, start takes effect only when mv_ready=1 in the same cycle.
REQ-016 In ACCUM, each cycle with in_valid=1 SHALL accept in_cand and increment the 5-bit row counter.
REQ-017 An accepted candidate SHALL replace best only if its SAD is strictly less than best SAD; on a tie the earlier candidate is kept.
REQ-018 On acceptance of row NUM_ROWS, the state SHALL become DONE and mv_valid SHALL assert on the next cycle, carrying the final best including that row (latency 1 cycle).
REQ-019 In DONE, mv_valid, mv_sad, mv_x and mv_y SHALL hold stable until mv_ready=1, after which the state becomes IDLE and mv_valid deasserts on the next cycle.
REQ-020 start during ACCUM SHALL abort the current search and restart it per REQ-015, with no mv_valid produced for the aborted block.
REQ-021 in_valid=1 in IDLE, or in DONE with mv_valid held, SHALL be discarded and SHALL set drop_err.
REQ-022 When start and in_valid are both high in ACCUM, the restart SHALL win and the candidate SHALL be discarded without setting drop_err.
REQ-023 A candidate whose packed value is 20'hFFF00 (the upstream idle pattern) with in_valid=1 SHALL be processed as an ordinary candidate.
REQ-024 mv_sad, mv_x and mv_y SHALL read zero whenever mv_valid=0.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, the row counter to 0, best to {all-ones,0,0}, mv_valid=0, busy=0 and drop_err=0, and SHALL drive mv_sad, mv_x and mv_y to 0.
REQ-026 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result; after release the block waits for start.

Configuration
REQ-027 With macro MV_SELECT_EARLY_TERM_EN defined, an accepted candidate with SAD=0 SHALL end ACCUM immediately (DONE, mv_valid the next cycle, result = that candidate) regardless of the row count.
REQ-028 Without MV_SELECT_EARLY_TERM_EN, a SAD=0 candidate SHALL be treated per REQ-017, and the search always completes after NUM_ROWS rows.

Verification
REQ-029 The bench SHALL drive start, then 16 rows with SAD 100..85 decreasing and y=0..15, x=3, with mv_ready=1; mv_valid SHALL pulse one cycle after row 16 with sad=85, x=3, y=15.
REQ-030 The bench SHALL send rows with SAD 50 at y=2 and y=9 (all other SADs 200); the result SHALL be sad=50 and y=2.
REQ-031 The bench SHALL hold mv_ready=0 for 5 cycles after mv_valid while pulsing in_valid; the outputs SHALL stay stable and drop_err SHALL be 1, then mv_ready=1 SHALL return the block to IDLE.
REQ-032 The bench SHALL pulse start after 7 rows, then send 16 rows with minimum SAD 40 at y=4; exactly one mv_valid SHALL appear, with sad=40 and y=4.
REQ-033 The bench SHALL assert rst_n=0 during row 10; all outputs SHALL be 0 immediately, and no mv_valid SHALL appear until a new start and 16 rows.
REQ-034 With MV_SELECT_EARLY_TERM_EN defined, the bench SHALL send SAD=0 at row 5 (x=6, y=4); mv_valid SHALL assert the next cycle with sad=0, x=6, y=4. Without the macro, mv_valid SHALL assert only after row 16, still with sad=0, x=6, y=4.

Source files
------------

// File: rtl/mv_select.sv
// rtl/mv_select.sv - best-motion-vector selector over NUM_ROWS row minima per search block
// Optional: define MV_SELECT_EARLY_TERM_EN to end a search on the first SAD=0 candidate.
module mv_select #(
    parameter int NUM_ROWS = 16,
    parameter int SAD_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [19:0]      in_cand,
    input  logic             mv_ready,
    output logic             mv_valid,
    output logic [SAD_W-1:0] mv_sad,
    output logic [3:0]       mv_x,
    output logic [3:0]       mv_y,
    output logic             busy,
    output logic             drop_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       row_cnt_q, row_cnt_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [3:0]       best_x_q, best_x_d;
    logic [3:0]       best_y_q, best_y_d;
    logic             drop_err_q, drop_err_d;

    logic [SAD_W-1:0] cand_sad;
    logic             load, accept, drop, better, last_row, zero_hit, finish;

    assign cand_sad = SAD_W'(in_cand[19:8]);
    assign better   = cand_sad < best_sad_q;
    assign last_row = row_cnt_q == 5'(NUM_ROWS - 1);

`ifdef MV_SELECT_EARLY_TERM_EN
    assign zero_hit = cand_sad == '0;
`else
    assign zero_hit = 1'b0;
`endif

    // In DONE the result is still owned by the consumer, so start waits for mv_ready.
    assign load   = start && ((state_q == IDLE) || (state_q == ACCUM) ||
                              ((state_q == DONE) && mv_ready));
    assign accept = (state_q == ACCUM) && in_valid && !start;
    assign drop   = in_valid && ((state_q == IDLE) || (state_q == DONE));
    assign finish = accept && (last_row || zero_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM: begin
                if (start)       state_d = ACCUM;
                else if (finish) state_d = DONE;
            end
            DONE:    if (mv_ready) state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mv_valid = state_q == DONE;
        busy     = state_q == ACCUM;
        drop_err = drop_err_q;
        mv_sad   = mv_valid ? best_sad_q : '0;
        mv_x     = mv_valid ? best_x_q : 4'd0;
        mv_y     = mv_valid ? best_y_q : 4'd0;
    end

    always_comb begin
        row_cnt_d  = row_cnt_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        drop_err_d = drop_err_q;
        if (load) begin
            row_cnt_d  = 5'd0;
            best_sad_d = '1;
            best_x_d   = 4'd0;
            best_y_d   = 4'd0;
            drop_err_d = 1'b0;
        end else begin
            if (drop) drop_err_d = 1'b1;
            if (accept) begin
                row_cnt_d = row_cnt_q + 5'd1;
                // Strict compare keeps the earlier candidate on a tie.
                if (better) begin
                    best_sad_d = cand_sad;
                    best_x_d   = in_cand[7:4];
                    best_y_d   = in_cand[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q  <= 5'd0;
            best_sad_q <= '1;
            best_x_q   <= 4'd0;
            best_y_q   <= 4'd0;
            drop_err_q <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            drop_err_q <= drop_err_d;
        end
    end

endmodule
